// File: rtl/block_mm_pkg.sv
// Shared types and default sizes for the block matrix-multiply datapath
// (tile multiplier, accumulator and later write-back stages).
package block_mm_pkg;

  localparam int TN  = 4;
  localparam int NKB = 4;
  localparam int W   = 16;

  typedef logic [W-1:0] word_t;
  typedef word_t [0:TN-1][0:TN-1] tile_t;

  typedef enum logic [0:0] {
    ACC  = 1'b0,
    FULL = 1'b1
  } state_t;

endpackage

// File: rtl/tile_add.sv
// Purely combinational elementwise adder of two Tn x Tn tiles, modulo 2^W.
module tile_add #(
  parameter int Tn = block_mm_pkg::TN,
  parameter int W  = block_mm_pkg::W
) (
  input  logic [0:Tn-1][0:Tn-1][W-1:0] a,
  input  logic [0:Tn-1][0:Tn-1][W-1:0] b,
  output logic [0:Tn-1][0:Tn-1][W-1:0] sum
);

  // elementwise sum; the carry out of each element is dropped on purpose
  always_comb begin
    sum = '0;
    for (int r = 0; r < Tn; r++) begin
      for (int c = 0; c < Tn; c++) begin
        sum[r][c] = a[r][c] + b[r][c];
      end
    end
  end

endmodule

// File: rtl/block_acc.sv
// Sums NKB consecutive partial-product tiles into one C tile and hands the
// result to the consumer over a valid/ready handshake.
module block_acc #(
  parameter int Tn  = block_mm_pkg::TN,
  parameter int NKB = block_mm_pkg::NKB,
  parameter int W   = block_mm_pkg::W
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          clear,
  input  logic [0:Tn-1][0:Tn-1][W-1:0]  tile_in,
  input  logic                          tile_valid,
  output logic                          in_ready,
  output logic [0:Tn-1][0:Tn-1][W-1:0]  out_tile,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [$clog2(NKB+1)-1:0]      kb,
  output logic                          err
);
  import block_mm_pkg::*;

  localparam int KBW = $clog2(NKB + 1);
  localparam logic [KBW-1:0] KB_LAST = KBW'(NKB - 1);
  localparam logic [KBW-1:0] KB_ZERO = {KBW{1'b0}};
  localparam logic [KBW-1:0] KB_ONE  = KBW'(1);

  state_t                         state_r;
  state_t                         state_nxt_s;
  logic [KBW-1:0]                 kb_r;
  logic [KBW-1:0]                 kb_nxt_s;
  logic [0:Tn-1][0:Tn-1][W-1:0]   acc_r;
  logic [0:Tn-1][0:Tn-1][W-1:0]   acc_nxt_s;
  logic [0:Tn-1][0:Tn-1][W-1:0]   sum_s;
  logic                           out_valid_r;
  logic                           err_r;
  logic                           accept_s;
  logic                           drop_s;

  tile_add #(.Tn(Tn), .W(W)) u_tile_add (
    .a   (acc_r),
    .b   (tile_in),
    .sum (sum_s)
  );

  // a held tile frees the input slot in the same cycle it is taken
  assign in_ready = (state_r == ACC) || ((state_r == FULL) && out_ready);
  assign accept_s = tile_valid && in_ready;
  assign drop_s   = tile_valid && !in_ready;

  // next-state: first block overwrites acc, later blocks add, last one parks in FULL
  always_comb begin
    state_nxt_s = state_r;
    kb_nxt_s    = kb_r;
    acc_nxt_s   = acc_r;
    if (accept_s) begin
      if (kb_r == KB_ZERO) begin
        acc_nxt_s = tile_in;
      end else begin
        acc_nxt_s = sum_s;
      end
      if (kb_r == KB_LAST) begin
        kb_nxt_s    = KB_ZERO;
        state_nxt_s = FULL;
      end else begin
        kb_nxt_s    = kb_r + KB_ONE;
        state_nxt_s = ACC;
      end
    end else if ((state_r == FULL) && out_ready) begin
      state_nxt_s = ACC;
    end else begin
      state_nxt_s = state_r;
    end
  end

  // state registers; clear outranks any same-cycle tile or handshake
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= ACC;
      kb_r        <= KB_ZERO;
      acc_r       <= '0;
      out_valid_r <= 1'b0;
      err_r       <= 1'b0;
    end else if (clear) begin
      state_r     <= ACC;
      kb_r        <= KB_ZERO;
      acc_r       <= '0;
      out_valid_r <= 1'b0;
      err_r       <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      kb_r        <= kb_nxt_s;
      acc_r       <= acc_nxt_s;
      out_valid_r <= (state_nxt_s == FULL);
      err_r       <= err_r || drop_s;
    end
  end

  assign out_tile  = acc_r;
  assign out_valid = out_valid_r;
  assign kb        = kb_r;
  assign err       = err_r;

endmodule
